// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EXE operand forwarding, load-use stall, branch
// flush, data-memory wait freeze with timeout detection.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise stall_count/flush_count are tied to zero.
module hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_id,
  input  logic [4:0]  Rt_id,
  input  logic        uses_rt_id,
  input  logic [4:0]  Rs_exe,
  input  logic [4:0]  Rt_exe,
  input  logic [4:0]  regaddr_exe,
  input  logic        regwrite_exe,
  input  logic        memtoreg_exe,
  input  logic [4:0]  regaddr_mem,
  input  logic [4:0]  regaddr_wb,
  input  logic        regwrite_mem,
  input  logic        regwrite_wb,
  input  logic        branch_taken_id,
  input  logic        mem_req_mem,
  input  logic        mem_ready,
  output logic [1:0]  forwardA_exe,
  output logic [1:0]  forwardB_exe,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idexe,
  output logic        freeze,
  output logic        mem_timeout,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StError   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;
  logic       mem_wait;
  logic       mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  // Forwarding source select; the MEM stage holds the younger value so it wins.
  always_comb begin
    mem_hit_a = regwrite_mem && (regaddr_mem != 5'd0) && (regaddr_mem == Rs_exe);
    mem_hit_b = regwrite_mem && (regaddr_mem != 5'd0) && (regaddr_mem == Rt_exe);
    wb_hit_a  = regwrite_wb && (regaddr_wb != 5'd0) && (regaddr_wb == Rs_exe);
    wb_hit_b  = regwrite_wb && (regaddr_wb != 5'd0) && (regaddr_wb == Rt_exe);
    if (mem_hit_a)     forwardA_exe = 2'b10;
    else if (wb_hit_a) forwardA_exe = 2'b01;
    else               forwardA_exe = 2'b00;
    if (mem_hit_b)     forwardB_exe = 2'b10;
    else if (wb_hit_b) forwardB_exe = 2'b01;
    else               forwardB_exe = 2'b00;
  end

  // Stall/flush priority: memory freeze, then load-use, then taken branch.
  always_comb begin
    load_use = memtoreg_exe && regwrite_exe && (regaddr_exe != 5'd0) &&
               ((regaddr_exe == Rs_id) || (uses_rt_id && (regaddr_exe == Rt_id)));
    mem_wait    = mem_req_mem && !mem_ready;
    freeze      = mem_wait;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idexe = 1'b0;
    if (mem_wait) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      flush_idexe = 1'b1;
    end else if (branch_taken_id) begin
      flush_ifid = 1'b1;
    end
  end

  // Memory-wait FSM next state; ERROR is only left through reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StRun: begin
        if (mem_wait) begin
          wait_cnt_d = 8'd1;
          state_d    = (TIMEOUT <= 8'd1) ? StError : StMemWait;
        end
      end
      StMemWait: begin
        if (!mem_wait) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else begin
          // Saturate so the counter can never wrap past TIMEOUT.
          if (wait_cnt_q < TIMEOUT) wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d >= TIMEOUT) state_d = StError;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_timeout = (state_q == StError);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, flush_count_q;

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (stall_pc)                  stall_count_q <= stall_count_q + 32'd1;
      if (flush_ifid || flush_idexe) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued as each cycle's
// stimulus is applied and compared on the following falling edge.
module tb_hazard_ctrl;

  localparam logic [7:0] Timeout = 8'd255;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs_id, Rt_id, Rs_exe, Rt_exe, regaddr_exe, regaddr_mem, regaddr_wb;
  logic        uses_rt_id, regwrite_exe, memtoreg_exe, regwrite_mem, regwrite_wb;
  logic        branch_taken_id, mem_req_mem, mem_ready;
  logic [1:0]  forwardA_exe, forwardB_exe;
  logic        stall_pc, stall_ifid, flush_ifid, flush_idexe, freeze, mem_timeout;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.TIMEOUT(Timeout)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .Rs_id          (Rs_id),
    .Rt_id          (Rt_id),
    .uses_rt_id     (uses_rt_id),
    .Rs_exe         (Rs_exe),
    .Rt_exe         (Rt_exe),
    .regaddr_exe    (regaddr_exe),
    .regwrite_exe   (regwrite_exe),
    .memtoreg_exe   (memtoreg_exe),
    .regaddr_mem    (regaddr_mem),
    .regaddr_wb     (regaddr_wb),
    .regwrite_mem   (regwrite_mem),
    .regwrite_wb    (regwrite_wb),
    .branch_taken_id(branch_taken_id),
    .mem_req_mem    (mem_req_mem),
    .mem_ready      (mem_ready),
    .forwardA_exe   (forwardA_exe),
    .forwardB_exe   (forwardB_exe),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .flush_ifid     (flush_ifid),
    .flush_idexe    (flush_idexe),
    .freeze         (freeze),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: 0 run, 1 waiting, 2 error.
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (regwrite_mem && regaddr_mem != 5'd0 && regaddr_mem == src) return 2'b10;
    if (regwrite_wb && regaddr_wb != 5'd0 && regaddr_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  // {stall_pc, stall_ifid, flush_ifid, flush_idexe, freeze}
  function automatic logic [4:0] ctrl_model();
    logic lu;
    lu = memtoreg_exe && regwrite_exe && regaddr_exe != 5'd0 &&
         (regaddr_exe == Rs_id || (uses_rt_id && regaddr_exe == Rt_id));
    if (mem_req_mem && !mem_ready) return 5'b11001;
    if (lu) return 5'b11010;
    if (branch_taken_id) return 5'b00100;
    return 5'b00000;
  endfunction

  // Scoreboard drain: every queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] obs;
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {30'd0, forwardA_exe};
        1:       obs = {30'd0, forwardB_exe};
        2:       obs = {27'd0, stall_pc, stall_ifid, flush_ifid, flush_idexe, freeze};
        3:       obs = {31'd0, mem_timeout};
        4:       obs = stall_count;
        default: obs = flush_count;
      endcase
      check_eq(e.tag, obs, e.val);
    end
  end

  // One clock cycle with the currently driven inputs.
  task automatic step();
    logic [4:0] c;
    logic       mw;
    if (!rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_stall = 32'd0;
      m_flush = 32'd0;
    end
    c  = ctrl_model();
    mw = mem_req_mem && !mem_ready;
    push_exp("fwdA", 0, {30'd0, fwd_model(Rs_exe)});
    push_exp("fwdB", 1, {30'd0, fwd_model(Rt_exe)});
    push_exp("ctrl", 2, {27'd0, c});
    push_exp("mem_timeout", 3, {31'd0, (m_state == 2)});
    push_exp("stall_count", 4, m_stall);
    push_exp("flush_count", 5, m_flush);
    @(negedge clk);
    @(posedge clk);
    #1;
    if (rst) begin
`ifdef HAZARD_PERF_EN
      if (c[4]) m_stall = m_stall + 32'd1;
      if (c[2] || c[1]) m_flush = m_flush + 32'd1;
`endif
      case (m_state)
        0: if (mw) begin
          m_cnt   = 1;
          m_state = (int'(Timeout) <= 1) ? 2 : 1;
        end
        1: if (!mw) begin
          m_state = 0;
          m_cnt   = 0;
        end else begin
          if (m_cnt < int'(Timeout)) m_cnt = m_cnt + 1;
          if (m_cnt == int'(Timeout)) m_state = 2;
        end
        default: m_state = 2;
      endcase
    end
  endtask

  task automatic idle_inputs();
    {Rs_id, Rt_id, Rs_exe, Rt_exe, regaddr_exe, regaddr_mem, regaddr_wb} = '0;
    {uses_rt_id, regwrite_exe, memtoreg_exe, regwrite_mem, regwrite_wb} = '0;
    {branch_taken_id, mem_req_mem} = '0;
    mem_ready = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    // Reset state, combinational outputs live during reset.
    push_exp("rst_timeout", 3, 32'd0);
    push_exp("rst_stall_cnt", 4, 32'd0);
    step();
    mem_req_mem = 1'b1;
    mem_ready   = 1'b0;
    push_exp("rst_freeze_live", 2, 32'b11001);
    step();
    idle_inputs();
    rst = 1'b1;
    step();

    // Load-use for four cycles, then two taken branches.
    memtoreg_exe = 1'b1;
    regwrite_exe = 1'b1;
    regaddr_exe  = 5'd7;
    Rs_id        = 5'd7;
    branch_taken_id = 1'b1;
    push_exp("loaduse_beats_branch", 2, 32'b11010);
    step();
    branch_taken_id = 1'b0;
    Rs_id = 5'd3;
    Rt_id = 5'd7;
    uses_rt_id = 1'b1;
    push_exp("loaduse_rt", 2, 32'b11010);
    step();
    step();
    step();
    idle_inputs();
    Rt_id = 5'd7;
    regaddr_exe = 5'd7;
    memtoreg_exe = 1'b1;
    regwrite_exe = 1'b1;
    branch_taken_id = 1'b1;
    push_exp("rt_unused_branch", 2, 32'b00100);
    step();
    step();
    idle_inputs();
`ifdef HAZARD_PERF_EN
    push_exp("perf_stall4", 4, 32'd4);
    push_exp("perf_flush6", 5, 32'd6);
`else
    push_exp("perf_stall0", 4, 32'd0);
    push_exp("perf_flush0", 5, 32'd0);
`endif
    step();

    // Forwarding priority and register zero.
    regwrite_mem = 1'b1;
    regaddr_mem  = 5'd5;
    Rs_exe       = 5'd5;
    regwrite_wb  = 1'b1;
    regaddr_wb   = 5'd5;
    push_exp("fwdA_mem_prio", 0, 32'd2);
    step();
    regwrite_mem = 1'b0;
    Rt_exe = 5'd5;
    push_exp("fwdB_wb", 1, 32'd1);
    step();
    regaddr_wb = 5'd0;
    Rt_exe     = 5'd0;
    push_exp("fwdB_r0", 1, 32'd0);
    step();
    idle_inputs();

    // Short memory wait: three frozen cycles, then ready.
    mem_req_mem = 1'b1;
    mem_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp("wait_freeze", 2, 32'b11001);
      step();
    end
    mem_ready = 1'b1;
    push_exp("wait_release", 2, 32'b00000);
    step();
    idle_inputs();
    push_exp("wait_no_timeout", 3, 32'd0);
    step();

    // Randomised hazard mix.
    for (int i = 0; i < 200; i++) begin
      Rs_id  = 5'($urandom_range(7));
      Rt_id  = 5'($urandom_range(7));
      Rs_exe = 5'($urandom_range(7));
      Rt_exe = 5'($urandom_range(7));
      regaddr_exe = 5'($urandom_range(7));
      regaddr_mem = 5'($urandom_range(7));
      regaddr_wb  = 5'($urandom_range(7));
      {uses_rt_id, regwrite_exe, memtoreg_exe, regwrite_mem, regwrite_wb} = 5'($urandom);
      branch_taken_id = 1'($urandom);
      mem_req_mem     = 1'($urandom);
      mem_ready       = ($urandom_range(3) != 0);
      step();
    end
    idle_inputs();
    step();

    // Reset in the middle of a wait abandons it.
    mem_req_mem = 1'b1;
    mem_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;
    push_exp("midwait_rst_timeout", 3, 32'd0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();

    // Long wait into the timeout error.
    mem_req_mem = 1'b1;
    mem_ready   = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 255) push_exp("timeout_not_yet", 3, 32'd0);
      if (i == 256) push_exp("timeout_set", 3, 32'd1);
      if (i == 300) push_exp("timeout_sticky", 3, 32'd1);
      step();
    end
    idle_inputs();
    branch_taken_id = 1'b1;
    push_exp("error_still_flushes", 2, 32'b00100);
    push_exp("error_held", 3, 32'd1);
    step();
    idle_inputs();
    rst = 1'b0;
    push_exp("error_cleared", 3, 32'd0);
    step();
    rst = 1'b1;
    step();
    push_exp("post_rst_timeout", 3, 32'd0);
    step();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
